uart_mmio_fifo: RTL and testbench

Memory-mapped 8N1 UART peripheral for the SoC IO page. It replaces the bare transmitter/receiver pair with parametrised TX and RX FIFOs, a runtime-programmable baud divisor, sticky error flags and an interrupt output. It sits behind the IO decode: the SoC drives `sel` when an IO access targets the UART window, and the CPU sees one-cycle registered read data, the same latency as the RAM.

---
 rtl/uart_mmio_fifo.sv | 244 ++++++++++++++++++++++++
 tb/tb_uart_mmio_fifo.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_fifo.sv
// uart_mmio_fifo: memory-mapped 8N1 UART with TX/RX FIFOs, programmable
// baud divisor, sticky error flags and a level interrupt.
//
// Ports:
//   clk, resetn            system clock, async active-low reset
//   sel, addr, wdata,      IO-page access: addr 0 DATA, 1 STATUS, 2 DIV, 3 IEN
//   wstrb, rstrb           strobes, qualified by sel
//   rdata                  registered read data, valid the cycle after a read
//   rx, tx                 serial lines (rx asynchronous, tx idles high)
//   irq                    (IEN[0] & rx_valid) | (IEN[1] & tx_idle)
//
// Both serial FSMs use the same encoding:
//   state   | meaning
//   S_IDLE  | no frame; TX waits for FIFO data, RX waits for a falling edge
//   S_START | start bit (RX: half-bit wait, then start re-check)
//   S_DATA  | 8 data bits, LSB first
//   S_STOP  | stop bit (RX: stop sample, then push or flag)
module uart_mmio_fifo #(
  parameter int          TX_DEPTH    = 16,
  parameter int          RX_DEPTH    = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd234
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic        wstrb,
  input  logic        rstrb,
  output logic [31:0] rdata,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;

  // Pointers carry one extra bit so that full and empty are distinct.
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [TX_AW:0] tx_wptr_q, tx_rptr_q, tx_level;
  logic [RX_AW:0] rx_wptr_q, rx_rptr_q, rx_level;
  logic           tx_full, tx_empty, rx_full, rx_empty;

  logic [15:0] div_q;
  logic [1:0]  ien_q;
  logic        overrun_q, frame_err_q;
  logic [31:0] rdata_q, rdata_d;

  logic [1:0]  tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_line_q, tx_line_d, tx_pop, tx_push, tx_idle;

  logic [1:0]  rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic        rx_push, rx_pop, set_ovr, set_fe;

  logic wr_en, rd_en;

  assign wr_en    = sel & wstrb;
  assign rd_en    = sel & rstrb;
  assign tx_level = tx_wptr_q - tx_rptr_q;
  assign rx_level = rx_wptr_q - rx_rptr_q;
  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign tx_full  = (tx_level == (TX_AW+1)'(TX_DEPTH));
  assign rx_full  = (rx_level == (RX_AW+1)'(RX_DEPTH));
  assign tx_push  = wr_en & (addr == 2'd0) & ~tx_full;
  assign rx_pop   = rd_en & (addr == 2'd0) & ~rx_empty;
  assign tx_idle  = (tx_state_q == S_IDLE) & tx_empty;
  assign tx       = tx_line_q;
  assign rdata    = rdata_q;
  assign irq      = (ien_q[0] & ~rx_empty) | (ien_q[1] & tx_idle);

  always_comb begin
    rdata_d = 32'd0;
    case (addr)
      2'd0: if (!rx_empty) rdata_d = {1'b1, 23'd0, rx_mem[rx_rptr_q[RX_AW-1:0]]};
      2'd1: rdata_d = {8'(tx_level), 8'(rx_level), 11'd0, frame_err_q, overrun_q,
                       tx_idle, ~rx_empty, ~tx_full};
      2'd2: rdata_d = {16'd0, div_q};
      default: rdata_d = {30'd0, ien_q};
    endcase
  end

  // TX: a new frame is loaded from IDLE or straight out of the last STOP
  // cycle, so back-to-back bytes leave no idle gap. DIV is latched per frame.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: tx_pop = ~tx_empty;
      S_START: begin
        if (tx_cnt_q == 16'd0) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = tx_div_q - 16'd1;
          tx_bit_d   = 3'd0;
          tx_line_d  = tx_shift_q[0];
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      S_DATA: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = tx_div_q - 16'd1;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
            tx_line_d  = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      default: begin
        if (tx_cnt_q == 16'd0) begin
          tx_state_d = S_IDLE;
          tx_pop     = ~tx_empty;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
    endcase
    if (tx_pop) begin
      tx_state_d = S_START;
      tx_shift_d = tx_mem[tx_rptr_q[TX_AW-1:0]];
      tx_div_d   = div_q;
      tx_cnt_d   = div_q - 16'd1;
      tx_line_d  = 1'b0;
    end
  end

  // RX: a full FIFO still accepts the byte when the CPU pops in that cycle.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    set_ovr    = 1'b0;
    set_fe     = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = S_START;
          rx_div_d   = div_q;
          rx_cnt_d   = {1'b0, div_q[15:1]} - 16'd1;
        end
      end
      S_START: begin
        if (rx_cnt_q == 16'd0) begin
          rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
          rx_cnt_d   = rx_div_q - 16'd1;
          rx_bit_d   = 3'd0;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      S_DATA: begin
        if (rx_cnt_q == 16'd0) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_cnt_d   = rx_div_q - 16'd1;
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      default: begin
        if (rx_cnt_q == 16'd0) begin
          rx_state_d = S_IDLE;
          if (!rx_s2_q)               set_fe  = 1'b1;
          else if (rx_full && !rx_pop) set_ovr = 1'b1;
          else                         rx_push = 1'b1;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q[TX_AW-1:0]] <= wdata[7:0];
    if (rx_push) rx_mem[rx_wptr_q[RX_AW-1:0]] <= rx_shift_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q     <= 32'd0;
      div_q       <= DEFAULT_DIV;
      ien_q       <= 2'd0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      tx_wptr_q   <= '0;
      tx_rptr_q   <= '0;
      rx_wptr_q   <= '0;
      rx_rptr_q   <= '0;
      tx_state_q  <= S_IDLE;
      tx_cnt_q    <= 16'd0;
      tx_div_q    <= 16'd0;
      tx_bit_q    <= 3'd0;
      tx_shift_q  <= 8'd0;
      tx_line_q   <= 1'b1;
      rx_state_q  <= S_IDLE;
      rx_cnt_q    <= 16'd0;
      rx_div_q    <= 16'd0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'd0;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
    end else begin
      if (rd_en) rdata_q <= rdata_d;
      if (wr_en && addr == 2'd2) div_q <= (wdata[15:0] < 16'd4) ? 16'd4 : wdata[15:0];
      if (wr_en && addr == 2'd3) ien_q <= wdata[1:0];
      // A new error event wins over a same-cycle clear so it is never lost.
      if (set_ovr) overrun_q <= 1'b1;
      else if (wr_en && addr == 2'd1 && wdata[3]) overrun_q <= 1'b0;
      if (set_fe) frame_err_q <= 1'b1;
      else if (wr_en && addr == 2'd1 && wdata[4]) frame_err_q <= 1'b0;
      if (tx_push) tx_wptr_q <= tx_wptr_q + {{TX_AW{1'b0}}, 1'b1};
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + {{TX_AW{1'b0}}, 1'b1};
      if (rx_push) rx_wptr_q <= rx_wptr_q + {{RX_AW{1'b0}}, 1'b1};
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + {{RX_AW{1'b0}}, 1'b1};
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_div_q    <= tx_div_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_line_q   <= tx_line_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_div_q    <= rx_div_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_s1_q     <= rx;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
    end
  end
endmodule

// File: tb/tb_uart_mmio_fifo.sv
module tb_uart_mmio_fifo;
  logic        clk = 1'b0, resetn = 1'b0;
  logic        sel = 1'b0, wstrb = 1'b0, rstrb = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        rx, tx, irq;
  logic        loop_en = 1'b0, rx_drv = 1'b1;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  int unsigned ncyc = 0;
  int unsigned falls[$];
  logic tx_prev = 1'b1;

  assign rx = loop_en ? tx : rx_drv;

  uart_mmio_fifo #(.TX_DEPTH(16), .RX_DEPTH(4), .DEFAULT_DIV(16'd234)) dut (
    .clk(clk), .resetn(resetn), .sel(sel), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .rstrb(rstrb), .rdata(rdata), .rx(rx), .tx(tx), .irq(irq));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    ncyc++;
    if (tx_prev === 1'b1 && tx === 1'b0) falls.push_back(ncyc);
    tx_prev = tx;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; wstrb = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; wstrb = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; rstrb = 1'b1; addr = a;
    @(negedge clk);
    sel = 1'b0; rstrb = 1'b0;
    d = rdata;
  endtask

  task automatic check_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(a, v);
    total++;
    if (v !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, v, exp);
    end
  endtask

  task automatic read_data_sb(input string name);
    logic [31:0] v, exp;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'd0;
    bus_read(2'd0, v);
    total++;
    if (v !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, v, exp);
    end
  endtask

  // Drives one 8N1 frame on rx. With pop_at_stop, a DATA read is issued in
  // the cycle whose clock edge performs the RX stop-sample push.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int div,
                            input bit pop_at_stop);
    int bi;
    logic [31:0] v, exp;
    for (int i = 0; i < 10 * div; i++) begin
      @(negedge clk);
      bi = i / div;
      rx_drv = (bi == 0) ? 1'b0 : (bi == 9) ? stop_bit : b[bi-1];
      if (pop_at_stop && i == 9 * div + div / 2 + 2) begin
        sel = 1'b1; rstrb = 1'b1; addr = 2'd0;
      end else if (pop_at_stop && i == 9 * div + div / 2 + 3) begin
        sel = 1'b0; rstrb = 1'b0;
        v = rdata;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'd0;
        total++;
        if (v !== exp) begin
          bad++;
          $display("FAIL pop_at_push: got %h expected %h", v, exp);
        end
      end
    end
    @(negedge clk);
    rx_drv = 1'b1;
  endtask

  task automatic test_reset();
    total++;
    if (tx !== 1'b1 || rdata !== 32'd0 || irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_pins: tx=%b rdata=%h irq=%b expected tx=1 rdata=0 irq=0", tx, rdata, irq);
    end
    check_reg("reset_status", 2'd1, 32'h0000_0005);
    check_reg("reset_div", 2'd2, 32'd234);
    check_reg("reset_ien", 2'd3, 32'd0);
  endtask

  task automatic test_tx_timing();
    logic [40:0] exp_tx, got_tx, exp_irq, got_irq;
    logic [7:0]  b;
    int w;
    b = 8'h01;
    bus_write(2'd2, 32'd1);
    check_reg("div_clamp", 2'd2, 32'd4);
    bus_write(2'd3, 32'd2);
    bus_write(2'd0, {24'd0, b});
    w = 0;
    while (tx !== 1'b0 && w < 3) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (w > 2) begin
      bad++;
      $display("FAIL tx_start_latency: got %0d cycles expected <=2", w);
    end
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) @(negedge clk);
      got_tx[k]  = tx;
      got_irq[k] = irq;
      w = k / 4;
      exp_tx[k]  = (k >= 40) ? 1'b1 : (w == 0) ? 1'b0 : (w == 9) ? 1'b1 : b[w-1];
      exp_irq[k] = (k >= 40);
    end
    total++;
    if (got_tx !== exp_tx) begin
      bad++;
      $display("FAIL tx_frame_bits: got %h expected %h", got_tx, exp_tx);
    end
    total++;
    if (got_irq !== exp_irq) begin
      bad++;
      $display("FAIL tx_idle_irq: got %h expected %h", got_irq, exp_irq);
    end
    check_reg("tx_done_status", 2'd1, 32'h0000_0005);
    bus_write(2'd3, 32'd0);
  endtask

  task automatic test_loopback();
    int unsigned t0;
    bit found;
    bus_write(2'd2, 32'd8);
    loop_en = 1'b1;
    falls.delete();
    bus_write(2'd0, 32'h55);
    exp_q.push_back(32'h8000_0055);
    bus_write(2'd0, 32'hA3);
    exp_q.push_back(32'h8000_00A3);
    repeat (200) @(negedge clk);
    found = 1'b0;
    t0 = (falls.size() > 0) ? falls[0] : 0;
    foreach (falls[i]) if (falls[i] == t0 + 80) found = 1'b1;
    total++;
    if (!found) begin
      bad++;
      $display("FAIL back_to_back_gap: no start bit at first_start+80 (first_start=%0d, falls=%0d) expected present",
               t0, falls.size());
    end
    read_data_sb("loop_byte0");
    read_data_sb("loop_byte1");
    loop_en = 1'b0;
  endtask

  task automatic test_overrun();
    logic [7:0] bytes [5] = '{8'h11, 8'hC4, 8'h00, 8'hFF, 8'h5A};
    for (int i = 0; i < 5; i++) begin
      send_frame(bytes[i], 1'b1, 8, 1'b0);
      if (i < 4) exp_q.push_back({1'b1, 23'd0, bytes[i]});
    end
    check_reg("overrun_status", 2'd1, 32'h0004_000F);
    bus_write(2'd1, 32'h08);
    check_reg("overrun_clear", 2'd1, 32'h0004_0007);
  endtask

  task automatic test_full_push_pop();
    send_frame(8'h3C, 1'b1, 8, 1'b1);
    exp_q.push_back(32'h8000_003C);
    check_reg("full_pushpop_status", 2'd1, 32'h0004_0007);
    for (int i = 0; i < 4; i++) read_data_sb("fifo_order");
    read_data_sb("empty_read");
  endtask

  task automatic test_frame_err_glitch();
    send_frame(8'h96, 1'b0, 8, 1'b0);
    repeat (4) @(negedge clk);
    check_reg("frame_err_set", 2'd1, 32'h0000_0015);
    bus_write(2'd1, 32'h00);
    check_reg("status_write0", 2'd1, 32'h0000_0015);
    bus_write(2'd1, 32'h10);
    check_reg("frame_err_clear", 2'd1, 32'h0000_0005);
    bus_write(2'd2, 32'd16);
    @(negedge clk);
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    check_reg("false_start", 2'd1, 32'h0000_0005);
  endtask

  task automatic test_irq();
    bus_write(2'd2, 32'd8);
    bus_write(2'd3, 32'd1);
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_empty: got %b expected 0", irq);
    end
    send_frame(8'h7E, 1'b1, 8, 1'b0);
    exp_q.push_back(32'h8000_007E);
    repeat (3) @(negedge clk);
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL irq_rx_valid: got %b expected 1", irq);
    end
    read_data_sb("irq_byte");
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_after_pop: got %b expected 0", irq);
    end
    bus_write(2'd3, 32'd0);
  endtask

  task automatic test_reset_midframe();
    bus_write(2'd2, 32'd8);
    bus_write(2'd0, 32'h00);
    bus_write(2'd0, 32'h00);
    repeat (30) @(negedge clk);
    total++;
    if (tx !== 1'b0) begin
      bad++;
      $display("FAIL midframe_tx: got %b expected 0", tx);
    end
    #2 resetn = 1'b0;
    #1;
    total++;
    if (tx !== 1'b1 || rdata !== 32'd0) begin
      bad++;
      $display("FAIL async_reset: tx=%b rdata=%h expected tx=1 rdata=0", tx, rdata);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    check_reg("post_reset_status", 2'd1, 32'h0000_0005);
    check_reg("post_reset_div", 2'd2, 32'd234);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    test_reset();
    test_tx_timing();
    test_loopback();
    test_overrun();
    test_full_push_pop();
    test_frame_err_glitch();
    test_irq();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
